// File: rtl/pipe_pkg.sv
// Shared encodings and configuration checks for the pipeline hazard/forwarding scoreboard.
package pipe_pkg;

  localparam int unsigned FWD_RF = 0;

  // Per-slot flags; the destination address is kept in a parallel vector because its width is a module parameter.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
  } slot_flags_t;

  function automatic int unsigned sel_width(input int unsigned nstage);
    return (nstage <= 2) ? 1 : int'($clog2(nstage));
  endfunction

  function automatic bit cfg_legal(input int unsigned nstage, input int unsigned nsrc,
                                   input int unsigned load_stage);
    return (nstage >= 2) && (nsrc >= 1) && (load_stage >= 1) && (load_stage <= nstage - 1);
  endfunction

endpackage

// File: rtl/pipe_scoreboard_prio.sv
// Youngest-match priority encoder: lowest slot index whose qualified destination equals addr_i.
module sb_prio_match #(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned AW     = 5,
  parameter int unsigned SW     = 2
) (
  input  logic [NSTAGE-1:0]    cand_i,
  input  logic [NSTAGE*AW-1:0] rd_i,
  input  logic [AW-1:0]        addr_i,
  output logic                 hit_o,
  output logic [SW-1:0]        idx_o
);

  // Scan oldest to youngest so the youngest hit is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (cand_i[NSTAGE-1-i] && (addr_i != '0) && (rd_i[(NSTAGE-1-i)*AW +: AW] == addr_i)) begin
        hit_o = 1'b1;
        idx_o = SW'(NSTAGE - 1 - i);
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard and forwarding controller: tracks in-flight destinations, raises load-use stalls, selects EX forwards.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter  int unsigned NSTAGE     = 3,
  parameter  int unsigned NSRC       = 2,
  parameter  int unsigned AW         = 5,
  parameter  int unsigned LOAD_STAGE = 2,
  parameter  int unsigned CNTW       = 32,
  localparam int unsigned SW         = sel_width(NSTAGE)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic [NSRC*AW-1:0] id_rs_i,
  input  logic [NSRC-1:0]    id_rs_used_i,
  input  logic [AW-1:0]      id_rd_i,
  input  logic               id_regwrite_i,
  input  logic               id_memread_i,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [NSRC*SW-1:0] ex_fwd_sel_o,
  output logic [CNTW-1:0]    stall_cnt_o
);

  if (!cfg_legal(NSTAGE, NSRC, LOAD_STAGE)) begin : g_bad_cfg
    $error("pipe_scoreboard: illegal NSTAGE/NSRC/LOAD_STAGE combination");
  end

  localparam logic [SW-1:0] LS    = SW'(LOAD_STAGE);
  localparam logic [SW-1:0] LS_M1 = SW'(LOAD_STAGE - 1);

  slot_flags_t [NSTAGE-1:0] slot_q, slot_d;
  logic [NSTAGE*AW-1:0]     rd_q, rd_d;
  logic [NSRC*AW-1:0]       ex_rs_q, ex_rs_d;
  logic [NSRC-1:0]          ex_used_q, ex_used_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;

  logic [NSTAGE-1:0]        wr_cand, fwd_cand, mr_vec;
  logic [NSRC-1:0]          st_hit, fw_hit, stall_src;
  logic [NSRC-1:0][SW-1:0]  st_idx, fw_idx;
  logic                     take;
  logic                     fwd_bad;

  always_comb begin
    wr_cand = '0;
    mr_vec  = '0;
    for (int unsigned p = 0; p < NSTAGE; p++) begin
      wr_cand[p] = slot_q[p].valid & slot_q[p].regwrite;
      mr_vec[p]  = slot_q[p].memread;
    end
  end

  // Slot 0 is the EX instruction itself, so it can never feed its own operands.
  assign fwd_cand = {wr_cand[NSTAGE-1:1], 1'b0};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    sb_prio_match #(.NSTAGE(NSTAGE), .AW(AW), .SW(SW)) u_stall_match (
      .cand_i (wr_cand),
      .rd_i   (rd_q),
      .addr_i (id_rs_i[s*AW +: AW]),
      .hit_o  (st_hit[s]),
      .idx_o  (st_idx[s])
    );

    sb_prio_match #(.NSTAGE(NSTAGE), .AW(AW), .SW(SW)) u_fwd_match (
      .cand_i (fwd_cand),
      .rd_i   (rd_q),
      .addr_i (ex_rs_q[s*AW +: AW]),
      .hit_o  (fw_hit[s]),
      .idx_o  (fw_idx[s])
    );

    // Stall only when the youngest producer is a load whose data is not yet forwardable.
    assign stall_src[s] = id_rs_used_i[s] & st_hit[s] & mr_vec[st_idx[s]] & (st_idx[s] < LS_M1);
    assign ex_fwd_sel_o[s*SW +: SW] = (slot_q[0].valid & ex_used_q[s] & fw_hit[s]) ? fw_idx[s]
                                                                                    : SW'(FWD_RF);
  end

  assign stall_o     = id_valid_i & ~flush_i & (|stall_src);
  assign take        = id_valid_i & ~stall_o & ~flush_i;
  assign ex_valid_o  = slot_q[0].valid;
  assign stall_cnt_o = cnt_q;

  always_comb begin
    slot_d    = slot_q;
    rd_d      = rd_q;
    ex_rs_d   = ex_rs_q;
    ex_used_d = ex_used_q;
    cnt_d     = cnt_q;
    if (!hold_i) begin
      for (int unsigned p = 1; p < NSTAGE; p++) begin
        slot_d[p]          = slot_q[p-1];
        rd_d[p*AW +: AW]   = rd_q[(p-1)*AW +: AW];
      end
      slot_d[0].valid    = take;
      slot_d[0].regwrite = take & id_regwrite_i;
      slot_d[0].memread  = take & id_memread_i;
      rd_d[AW-1:0]       = id_rd_i;
      ex_rs_d            = id_rs_i;
      ex_used_d          = id_rs_used_i;
      if (stall_o && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q    <= '0;
      rd_q      <= '0;
      ex_rs_q   <= '0;
      ex_used_q <= '0;
      cnt_q     <= '0;
    end else begin
      slot_q    <= slot_d;
      rd_q      <= rd_d;
      ex_rs_q   <= ex_rs_d;
      ex_used_q <= ex_used_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    fwd_bad = 1'b0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      if ((ex_fwd_sel_o[s*SW +: SW] != SW'(FWD_RF)) && mr_vec[ex_fwd_sel_o[s*SW +: SW]] &&
          (ex_fwd_sel_o[s*SW +: SW] < LS)) begin
        fwd_bad = 1'b1;
      end
    end
  end

  a_no_early_load_fwd: assert property (@(posedge clk_i) disable iff (rst_i) !fwd_bad);

endmodule
